bsg_cgol_cell_gen: RTL
======================

// Module: bsg_cgol_cell_gen
// PURPOSE
//  Parametrised Life-like cell with programmable birth/survive rules and Generations-style decay states.
//  Replaces the fixed B3/S23 two-state cell; sits in each position of the CGOL cell array.
//  Exposes an alive bit for neighbours, the full state, a change flag, and an optional alive-age counter.
// PARAMETERS
//  NEIGHBORS_P   8   number of neighbour inputs (8 = Moore, 4 = von Neumann)
//  STATES_P      2   total states incl. dead; 2 = classic Life, >2 adds STATES_P-2 decay states (min 2)
//  AGE_WIDTH_P   8   width of saturating alive-age counter (CGOL_CELL_AGE_EN only)
// PORTS
//  clk_i           in   1                    clock; all state updates on posedge
//  reset_n_i       in   1                    synchronous, active-low reset
//  en_i            in   1                    advance one generation
//  data_i          in   NEIGHBORS_P          neighbour alive bits (1 = alive)
//  birth_mask_i    in   NEIGHBORS_P+1        bit n set: dead cell with n live neighbours is born
//  survive_mask_i  in   NEIGHBORS_P+1        bit n set: live cell with n live neighbours survives
//  update_i        in   1                    load update_val_i (only when en_i=0)
//  update_val_i    in   state_w              state to load; state_w = $clog2(STATES_P)
//  data_o          out  1                    1 iff state == ALIVE
//  state_o         out  state_w              current state
//  changed_o       out  1                    1 for one cycle after a cycle in which state changed
//  age_o           out  AGE_WIDTH_P          generations survived while alive (CGOL_CELL_AGE_EN only)
// BEHAVIOUR
//  Encoding: 0 DEAD, 1 ALIVE, 2..STATES_P-1 DYING; DYING cells drive data_o=0.
//  Priority per posedge: !reset_n_i > en_i > update_i > hold.
//  Reset: state 0, data_o 0, changed_o 0, age_o 0.
//  n = popcount(data_i), width $clog2(NEIGHBORS_P+1); n indexes the masks directly.
//  en_i, DEAD: -> ALIVE if birth_mask_i[n], else DEAD.
//  en_i, ALIVE: stay ALIVE if survive_mask_i[n]; else DEAD (STATES_P==2) or state 2.
//  en_i, DYING k: -> k+1 regardless of neighbours; k==STATES_P-1 -> DEAD.
//  update_i with en_i=0: state <= update_val_i; values >= STATES_P load DEAD.
//  Single-cycle latency: state_o/data_o reflect the new state the cycle after the enabling edge.
//  changed_o is registered: (next_state != state) at each edge; cleared by reset.
//  Masks are sampled only on en_i edges; changing them mid-run takes effect next generation.
//  Reset during en_i or update_i wins; no partial update survives.
// CONFIGURATION
//  CGOL_CELL_AGE_EN defined:
//   - age_o present.
//   - On an en_i edge with ALIVE->ALIVE: age <= age+1, saturating at all-ones.
//   - Any transition out of ALIVE, any update_i load, or reset: age <= 0.
//   - DEAD->ALIVE birth: age <= 0.
//  Not defined: age_o port and counter absent; no other behaviour differs.
// STRUCTURE
//  Package bsg_cgol_pkg:
//   - state constants DEAD=0, ALIVE=1, FIRST_DYING=2.
//   - typedef for rule pair {birth_mask, survive_mask} parametrised by NEIGHBORS_P (via localparams in the cell).
//  Sub-module bsg_cgol_rule_eval (combinational):
//   - inputs popcount, state, masks; output next_state.
//   - Popcount uses the basejump count-ones macro.
//  Top holds the state register, changed flag and optional age counter.
// TESTING
//  B3/S23, STATES_P=2, DEAD, data_i=8'b0000_0111, en_i=1 -> next cycle state_o=1, data_o=1, changed_o=1.
//  ALIVE, data_i=8'b0000_1111 (n=4), S23 -> state_o=0; with n=2 -> stays 1, changed_o=0.
//  STATES_P=4 (Brian's Brain B2/S-):
//   - ALIVE with any n -> 2 -> 3 -> 0 on consecutive en_i edges.
//   - data_o=0 in states 2 and 3.
//  en_i=0, update_i=1, update_val_i=1 -> state_o=1.
//   - STATES_P=3, update_val_i=3 -> state_o=0.
//   - en_i=1 with update_i=1 -> rule result, update ignored.
//  AGE_EN, AGE_WIDTH_P=2:
//   - ALIVE surviving 5 generations -> age_o 1,2,3,3,3.
//   - Death -> age_o=0 next cycle.
//  reset_n_i=0 asserted together with en_i=1 and update_i=1, state ALIVE -> next cycle state_o=0, changed_o=0, age_o=0.

Source files
------------

// File: rtl/bsg_cgol_pkg.sv
// Shared constants and helpers for the Life-like cell: state codes, state classes
// and a popcount helper used to count live neighbours.
package bsg_cgol_pkg;

   localparam int DEAD        = 0;
   localparam int ALIVE       = 1;
   localparam int FIRST_DYING = 2;

   typedef enum logic [1:0] {
      CLASS_DEAD,
      CLASS_ALIVE,
      CLASS_DYING
   } state_class_e;

   // Count-ones over a zero-extended neighbour vector; callers truncate to their width.
   function automatic int unsigned countOnes(input logic [31:0] vec);
      int unsigned total;
      total = 0;
      for (int i = 0; i < 32; i++) begin
         total += 32'(vec[i]);
      end
      return total;
   endfunction

endpackage

// File: rtl/bsg_cgol_cell_gen_rule_eval.sv
// Combinational birth/survive/decay rule: maps the current state and live-neighbour
// count to the state for the next generation.
module bsg_cgol_rule_eval
   import bsg_cgol_pkg::*;
#(
   parameter  int NEIGHBORS_P = 8,
   parameter  int STATES_P    = 2,
   localparam int STATE_W     = $clog2(STATES_P),
   localparam int CNT_W       = $clog2(NEIGHBORS_P + 1)
) (
   input  logic [CNT_W-1:0]     count_i,
   input  logic [STATE_W-1:0]   state_i,
   input  logic [NEIGHBORS_P:0] birth_mask_i,
   input  logic [NEIGHBORS_P:0] survive_mask_i,
   output logic [STATE_W-1:0]   next_state_o
);

   localparam logic [STATE_W-1:0] DEAD_S        = STATE_W'(DEAD);
   localparam logic [STATE_W-1:0] ALIVE_S       = STATE_W'(ALIVE);
   localparam logic [STATE_W-1:0] FIRST_DYING_S = STATE_W'(FIRST_DYING);
   localparam logic [STATE_W-1:0] LAST_S        = STATE_W'(STATES_P - 1);

   state_class_e stateClass;

   always_comb begin
      stateClass = CLASS_DEAD;
      if (state_i == ALIVE_S) begin
         stateClass = CLASS_ALIVE;
      end else if (state_i != DEAD_S) begin
         stateClass = CLASS_DYING;
      end
   end

   // Dying cells walk up the decay chain and wrap to DEAD from the last (or any illegal) code.
   always_comb begin
      next_state_o = DEAD_S;
      case (stateClass)
         CLASS_DEAD: begin
            if (birth_mask_i[count_i]) begin
               next_state_o = ALIVE_S;
            end
         end
         CLASS_ALIVE: begin
            if (survive_mask_i[count_i]) begin
               next_state_o = ALIVE_S;
            end else if (STATES_P > 2) begin
               next_state_o = FIRST_DYING_S;
            end
         end
         CLASS_DYING: begin
            if (state_i < LAST_S) begin
               next_state_o = state_i + STATE_W'(1);
            end
         end
         default: next_state_o = DEAD_S;
      endcase
   end

endmodule

// File: rtl/bsg_cgol_cell_gen.sv
// One cell of the CGOL array with programmable birth/survive masks and decay states.
// Define CGOL_CELL_AGE_EN to add the saturating alive-age counter and its age_o port.
module bsg_cgol_cell_gen
   import bsg_cgol_pkg::*;
#(
   parameter  int NEIGHBORS_P = 8,
   parameter  int STATES_P    = 2,
   parameter  int AGE_WIDTH_P = 8,
   localparam int STATE_W     = $clog2(STATES_P)
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic                   en_i,
   input  logic [NEIGHBORS_P-1:0] data_i,
   input  logic [NEIGHBORS_P:0]   birth_mask_i,
   input  logic [NEIGHBORS_P:0]   survive_mask_i,
   input  logic                   update_i,
   input  logic [STATE_W-1:0]     update_val_i,
   output logic                   data_o,
   output logic [STATE_W-1:0]     state_o,
   output logic                   changed_o
`ifdef CGOL_CELL_AGE_EN
   ,
   output logic [AGE_WIDTH_P-1:0] age_o
`endif
);

   localparam int CNT_W = $clog2(NEIGHBORS_P + 1);
   localparam logic [STATE_W-1:0] DEAD_S  = STATE_W'(DEAD);
   localparam logic [STATE_W-1:0] ALIVE_S = STATE_W'(ALIVE);
   localparam logic [STATE_W-1:0] LAST_S  = STATE_W'(STATES_P - 1);

   typedef struct packed {
      logic [NEIGHBORS_P:0] birth_mask;
      logic [NEIGHBORS_P:0] survive_mask;
   } rule_t;

   rule_t              rules;
   logic [CNT_W-1:0]   liveCount;
   logic [STATE_W-1:0] ruleNext;
   logic [STATE_W-1:0] state_d, state_q;
   logic               changed_q;

   assign rules     = '{birth_mask: birth_mask_i, survive_mask: survive_mask_i};
   assign liveCount = CNT_W'(countOnes(32'(data_i)));

   bsg_cgol_rule_eval #(
      .NEIGHBORS_P (NEIGHBORS_P),
      .STATES_P    (STATES_P)
   ) ruleEval (
      .count_i        (liveCount),
      .state_i        (state_q),
      .birth_mask_i   (rules.birth_mask),
      .survive_mask_i (rules.survive_mask),
      .next_state_o   (ruleNext)
   );

   // A generation step outranks a host load; out-of-range load values fall back to DEAD.
   always_comb begin
      state_d = state_q;
      if (en_i) begin
         state_d = ruleNext;
      end else if (update_i) begin
         state_d = (update_val_i > LAST_S) ? DEAD_S : update_val_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q   <= DEAD_S;
         changed_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         changed_q <= (state_d != state_q);
      end
   end

   assign state_o   = state_q;
   assign data_o    = (state_q == ALIVE_S);
   assign changed_o = changed_q;

`ifdef CGOL_CELL_AGE_EN
   logic [AGE_WIDTH_P-1:0] age_d, age_q;

   // Age only grows across a surviving generation; births, deaths and loads restart it.
   always_comb begin
      age_d = age_q;
      if (en_i) begin
         if ((state_q == ALIVE_S) && (state_d == ALIVE_S)) begin
            age_d = (&age_q) ? age_q : age_q + AGE_WIDTH_P'(1);
         end else begin
            age_d = '0;
         end
      end else if (update_i) begin
         age_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         age_q <= '0;
      end else begin
         age_q <= age_d;
      end
   end

   assign age_o = age_q;
`endif

endmodule
